// File: rtl/stdp_pkg.sv
// Shared constants, types and the weight clamp helper for the STDP synapse.
// W_WIDTH/TRACE_WIDTH size the weight and trace registers; SUM_WIDTH is the
// signed width of the learning sum, wide enough for weight + ltp - ltd
// without overflow (range -255 .. +510).
package stdp_pkg;

  localparam int W_WIDTH     = 8;
  localparam int TRACE_WIDTH = 8;
  localparam int SUM_WIDTH   = 10;

  typedef logic [W_WIDTH-1:0] w_t;

  // Clamp a signed learning sum into [lo, hi]. The unsigned bounds are
  // zero-extended so the comparison happens in the signed domain.
  function automatic w_t clamp_w(input logic signed [SUM_WIDTH-1:0] v,
                                 input w_t lo,
                                 input w_t hi);
    logic signed [SUM_WIDTH-1:0] lo_s;
    logic signed [SUM_WIDTH-1:0] hi_s;
    w_t                          res;
    lo_s = $signed({{(SUM_WIDTH-W_WIDTH){1'b0}}, lo});
    hi_s = $signed({{(SUM_WIDTH-W_WIDTH){1'b0}}, hi});
    if (v < lo_s)      res = lo;
    else if (v > hi_s) res = hi;
    else               res = v[W_WIDTH-1:0];
    return res;
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// Exponentially decaying spike trace.
// A spike reloads the trace to TRACE_MAX; otherwise a non-zero trace loses
// trace>>DECAY_SHIFT per cycle, but at least 1, so it always reaches 0
// and never underflows.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (trace -> 0)
//   spike  spike level sampled on each posedge
//   trace  registered trace value
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int TRACE_MAX   = 255,
  parameter int DECAY_SHIFT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spike,
  output w_t   trace
);

  w_t shr;
  w_t dec;

  always_comb begin
    shr = trace >> DECAY_SHIFT;
    dec = (shr == '0) ? w_t'(1) : shr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)             trace <= '0;
    else if (spike)         trace <= w_t'(TRACE_MAX);
    else if (trace != '0)   trace <= trace - dec;
  end

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse with pair-based STDP.
// Converts pre-synaptic spikes into a one-cycle current pulse carrying the
// weight held before the spike edge, and learns the weight from pre/post
// spike timing using the pre and post traces held before the edge.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   pre_spike    upstream spike level, sampled per edge
//   post_spike   driven neuron's spike level, sampled per edge
//   learn_en     enables learning updates (traces always run)
//   weight_load  loads weight_in (unclamped), overriding learning
//   weight_in    value used by weight_load
//   current      registered current drive to the neuron
//   weight       weight register
//   pre_trace    pre-synaptic trace
//   post_trace   post-synaptic trace
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter int W_INIT      = 64,
  parameter int W_MIN       = 0,
  parameter int W_MAX       = 255,
  parameter int TRACE_MAX   = 255,
  parameter int DECAY_SHIFT = 2,
  parameter int LTP_SHIFT   = 3,
  parameter int LTD_SHIFT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  input  logic       weight_load,
  input  logic [7:0] weight_in,
  output logic [7:0] current,
  output logic [7:0] weight,
  output logic [7:0] pre_trace,
  output logic [7:0] post_trace
);

  w_t                          ltp;
  w_t                          ltd;
  logic signed [SUM_WIDTH-1:0] sum;
  w_t                          w_learn;

  stdp_trace #(.TRACE_MAX(TRACE_MAX), .DECAY_SHIFT(DECAY_SHIFT)) u_pre_trace (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (pre_spike),
    .trace (pre_trace)
  );

  stdp_trace #(.TRACE_MAX(TRACE_MAX), .DECAY_SHIFT(DECAY_SHIFT)) u_post_trace (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (post_spike),
    .trace (post_trace)
  );

  // Potentiation rewards a post spike following recent pre activity;
  // depression penalises a pre spike following recent post activity.
  // Both use the trace values from before this edge.
  always_comb begin
    ltp     = post_spike ? (pre_trace >> LTP_SHIFT) : '0;
    ltd     = pre_spike  ? (post_trace >> LTD_SHIFT) : '0;
    sum     = $signed({2'b00, weight}) + $signed({2'b00, ltp})
            - $signed({2'b00, ltd});
    w_learn = clamp_w(sum, w_t'(W_MIN), w_t'(W_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight  <= w_t'(W_INIT);
      current <= '0;
    end else begin
      current <= pre_spike ? weight : '0;
      if (weight_load)
        weight <= weight_in;
      else if (learn_en && (pre_spike || post_spike))
        weight <= w_learn;
    end
  end

endmodule
